// File: rtl/hist_pkg.sv
// Shared definitions for the histogram pipeline.
// Holds the controller state encoding, the fixed memory-interface widths, the
// default valid tag written above every bin count, and a helper that sizes the
// lane index from the number of pixels packed into one image word.
package hist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_COUNT = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int ADDR_W = 16;
  localparam int TAG_W  = 16;

  localparam int PIX_W_DEFAULT     = 8;
  localparam int WORD_W_DEFAULT    = 128;
  localparam int NUM_WORDS_DEFAULT = 16384;
  localparam int CNT_W_DEFAULT     = 16;

  localparam logic [TAG_W-1:0] TAG_DEFAULT = 16'hAAAA;

  // A lane index needs at least one bit, even with a single pixel per word.
  function automatic int lane_bits(input int pix_per_word);
    return (pix_per_word > 1) ? $clog2(pix_per_word) : 1;
  endfunction

endpackage

// File: rtl/hist_fwd_accum.sv
// Bin-count accumulator with read-after-write forwarding.
// Picks the base count for the bin currently in the ACC stage and returns it
// incremented with saturation.
//   i_bin     : bin addressed by the pixel in ACC
//   i_rd_val  : scratchpad word read for that bin (tag + count)
//   i_ss_*    : pixel one ahead, in SS this cycle (its write has not landed)
//   i_wr_*    : pixel two ahead, written on the same edge as our read
//   o_cnt     : saturated incremented count for i_bin
module hist_fwd_accum
  import hist_pkg::*;
#(
  parameter int               PIX_W  = PIX_W_DEFAULT,
  parameter int               WORD_W = WORD_W_DEFAULT,
  parameter int               CNT_W  = CNT_W_DEFAULT,
  parameter logic [TAG_W-1:0] TAG    = TAG_DEFAULT
) (
  input  logic [PIX_W-1:0]  i_bin,
  input  logic [WORD_W-1:0] i_rd_val,
  input  logic              i_ss_vld,
  input  logic [PIX_W-1:0]  i_ss_bin,
  input  logic [CNT_W-1:0]  i_ss_cnt,
  input  logic              i_wr_vld,
  input  logic [PIX_W-1:0]  i_wr_bin,
  input  logic [CNT_W-1:0]  i_wr_cnt,
  output logic [CNT_W-1:0]  o_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic [CNT_W-1:0] w_base;

  // The in-flight counts beat the scratchpad: the SS entry is the newest,
  // the just-written entry is invisible to a read-first memory on that edge.
  // Untagged scratchpad contents are stale garbage and count as zero.
  always_comb begin
    w_base = '0;
    if (i_ss_vld && (i_ss_bin == i_bin)) begin
      w_base = i_ss_cnt;
    end else if (i_wr_vld && (i_wr_bin == i_bin)) begin
      w_base = i_wr_cnt;
    end else if (i_rd_val[CNT_W +: TAG_W] == TAG) begin
      w_base = i_rd_val[CNT_W-1:0];
    end
  end

  assign o_cnt = sat_inc(w_base);

  // Bits above the tag carry no information.
  generate
    if (WORD_W > CNT_W + TAG_W) begin : g_pad
      logic w_unused_pad;
      assign w_unused_pad = ^i_rd_val[WORD_W-1:CNT_W+TAG_W];
    end
  endgenerate

endmodule

// File: rtl/hist_count_pipeline.sv
// Image histogram engine.
// Streams NUM_WORDS image words (PIX_PER_WORD pixels each, lane 0 first) from
// m1 and keeps one tagged counter per pixel value in the m2 scratchpad, one
// pixel per cycle through a four-stage pipeline FI -> FS -> ACC -> SS.
//   clock, rst_n          : clock, asynchronous active-low reset
//   start, clear_mode     : pass request; clear_mode=1 zeroes all bins first
//   m1ReadAddr/m1ReadVal  : image memory, synchronous read
//   m2ReadAddr/m2ReadVal  : scratchpad read port, synchronous read
//   m2WriteAddr/Val, m2WE : scratchpad write port
//   busy, done            : pass in progress / one-cycle completion pulse
module hist_count_pipeline
  import hist_pkg::*;
#(
  parameter int               PIX_W     = PIX_W_DEFAULT,
  parameter int               WORD_W    = WORD_W_DEFAULT,
  parameter int               NUM_WORDS = NUM_WORDS_DEFAULT,
  parameter int               CNT_W     = CNT_W_DEFAULT,
  parameter logic [TAG_W-1:0] TAG       = TAG_DEFAULT
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              start,
  input  logic              clear_mode,
  output logic [ADDR_W-1:0] m1ReadAddr,
  input  logic [WORD_W-1:0] m1ReadVal,
  output logic [ADDR_W-1:0] m2ReadAddr,
  input  logic [WORD_W-1:0] m2ReadVal,
  output logic [ADDR_W-1:0] m2WriteAddr,
  output logic [WORD_W-1:0] m2WriteVal,
  output logic              m2WE,
  output logic              busy,
  output logic              done
);

  localparam int PIX_PER_WORD = WORD_W / PIX_W;
  localparam int LANE_W       = lane_bits(PIX_PER_WORD);

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PIX_PER_WORD - 1);
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(NUM_WORDS - 1);

  function automatic logic [WORD_W-1:0] pack_bin(input logic [CNT_W-1:0] c);
    logic [WORD_W-1:0] v;
    v                = '0;
    v[CNT_W +: TAG_W] = TAG;
    v[CNT_W-1:0]     = c;
    return v;
  endfunction

  state_t r_state, w_next;

  logic [PIX_W-1:0]  r_clr_idx;
  logic [ADDR_W-1:0] r_word;
  logic [LANE_W-1:0] r_lane;

  logic              r_vld_p0, r_vld_p1, r_vld_p2, r_vld_p3;
  logic [LANE_W-1:0] r_lane_p0;
  logic [PIX_W-1:0]  r_bin_p1, r_bin_p2, r_bin_p3;
  logic [CNT_W-1:0]  r_cnt_p2, r_cnt_p3;

  logic              w_issue;
  logic              w_last_issue;
  logic [PIX_W-1:0]  w_pix_p0;
  logic [CNT_W-1:0]  w_acc_cnt_p1;

  assign w_issue      = (r_state == ST_COUNT);
  assign w_last_issue = w_issue && (r_word == LAST_WORD) && (r_lane == LAST_LANE);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (start) w_next = clear_mode ? ST_CLEAR : ST_COUNT;
      ST_CLEAR: if (r_clr_idx == '1) w_next = ST_COUNT;
      ST_COUNT: if (w_last_issue) w_next = ST_DRAIN;
      // Once FS and ACC are empty, the last pixel is writing in SS now.
      ST_DRAIN: if (!r_vld_p0 && !r_vld_p1) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_clr_idx <= '0;
      r_word    <= '0;
      r_lane    <= '0;
      r_vld_p0  <= 1'b0;
      r_vld_p1  <= 1'b0;
      r_vld_p2  <= 1'b0;
      r_vld_p3  <= 1'b0;
    end else begin
      r_state <= w_next;

      if (r_state == ST_CLEAR) r_clr_idx <= r_clr_idx + PIX_W'(1);
      else                     r_clr_idx <= '0;

      if (w_issue) begin
        if (r_lane == LAST_LANE) begin
          r_lane <= '0;
          r_word <= w_last_issue ? '0 : r_word + ADDR_W'(1);
        end else begin
          r_lane <= r_lane + LANE_W'(1);
        end
      end else begin
        r_lane <= '0;
        r_word <= '0;
      end

      r_vld_p0 <= w_issue;
      r_vld_p1 <= r_vld_p0;
      r_vld_p2 <= r_vld_p1;
      r_vld_p3 <= r_vld_p2;
    end
  end

  // FI -> FS: image word arrives, select the lane issued last cycle
  assign w_pix_p0 = m1ReadVal[int'(r_lane_p0)*PIX_W +: PIX_W];

  // FS -> ACC: scratchpad word for the bin arrives, form the new count
  hist_fwd_accum #(
    .PIX_W  (PIX_W),
    .WORD_W (WORD_W),
    .CNT_W  (CNT_W),
    .TAG    (TAG)
  ) u_fwd_accum (
    .i_bin    (r_bin_p1),
    .i_rd_val (m2ReadVal),
    .i_ss_vld (r_vld_p2),
    .i_ss_bin (r_bin_p2),
    .i_ss_cnt (r_cnt_p2),
    .i_wr_vld (r_vld_p3),
    .i_wr_bin (r_bin_p3),
    .i_wr_cnt (r_cnt_p3),
    .o_cnt    (w_acc_cnt_p1)
  );

  // ACC -> SS, and SS -> written record kept for forwarding
  always_ff @(posedge clock) begin
    r_lane_p0 <= r_lane;
    r_bin_p1  <= w_pix_p0;
    r_bin_p2  <= r_bin_p1;
    r_cnt_p2  <= w_acc_cnt_p1;
    r_bin_p3  <= r_bin_p2;
    r_cnt_p3  <= r_cnt_p2;
  end

  assign m1ReadAddr = w_issue  ? r_word             : '0;
  assign m2ReadAddr = r_vld_p0 ? ADDR_W'(w_pix_p0)   : '0;

  // CLEAR and SS writes never overlap: CLEAR is only entered from IDLE.
  always_comb begin
    m2WE        = 1'b0;
    m2WriteAddr = '0;
    m2WriteVal  = '0;
    if (r_state == ST_CLEAR) begin
      m2WE        = 1'b1;
      m2WriteAddr = ADDR_W'(r_clr_idx);
      m2WriteVal  = pack_bin('0);
    end else if (r_vld_p2) begin
      m2WE        = 1'b1;
      m2WriteAddr = ADDR_W'(r_bin_p2);
      m2WriteVal  = pack_bin(r_cnt_p2);
    end
  end

  assign busy = (r_state == ST_CLEAR) || (r_state == ST_COUNT) || (r_state == ST_DRAIN);
  assign done = (r_state == ST_DONE);

endmodule

// File: tb/tb_hist_count_pipeline.sv
// Directed bench for hist_count_pipeline: instance A uses CNT_W=16, instance B
// uses CNT_W=4; both run NUM_WORDS=2 (32 pixels per pass) against read-first
// synchronous memory models.
module tb_hist_count_pipeline;

  localparam int NW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start_a, cm_a, start_b, cm_b;

  logic [15:0]  m1_addr_a, m2_raddr_a, m2_waddr_a;
  logic [15:0]  m1_addr_b, m2_raddr_b, m2_waddr_b;
  logic [127:0] m1_rd_a, m2_rd_a, m2_wval_a;
  logic [127:0] m1_rd_b, m2_rd_b, m2_wval_b;
  logic         m2_we_a, busy_a, done_a;
  logic         m2_we_b, busy_b, done_b;

  logic [127:0] m1a [0:NW-1];
  logic [127:0] m1b [0:NW-1];
  logic [127:0] m2a [0:255];
  logic [127:0] m2b [0:255];

  logic         tb_we_a, tb_we_b;
  logic [7:0]   tb_waddr;
  logic [127:0] tb_wval;

  int wr_cnt_a = 0;
  int n_vec = 0;
  int n_err = 0;
  int exp_cnt [256];

  hist_count_pipeline #(.NUM_WORDS(NW), .CNT_W(16)) u_dut_a (
    .clock(clk), .rst_n(rst_n), .start(start_a), .clear_mode(cm_a),
    .m1ReadAddr(m1_addr_a), .m1ReadVal(m1_rd_a),
    .m2ReadAddr(m2_raddr_a), .m2ReadVal(m2_rd_a),
    .m2WriteAddr(m2_waddr_a), .m2WriteVal(m2_wval_a), .m2WE(m2_we_a),
    .busy(busy_a), .done(done_a)
  );

  hist_count_pipeline #(.NUM_WORDS(NW), .CNT_W(4)) u_dut_b (
    .clock(clk), .rst_n(rst_n), .start(start_b), .clear_mode(cm_b),
    .m1ReadAddr(m1_addr_b), .m1ReadVal(m1_rd_b),
    .m2ReadAddr(m2_raddr_b), .m2ReadVal(m2_rd_b),
    .m2WriteAddr(m2_waddr_b), .m2WriteVal(m2_wval_b), .m2WE(m2_we_b),
    .busy(busy_b), .done(done_b)
  );

  always @(posedge clk) begin
    m1_rd_a <= m1a[m1_addr_a[0]];
    m2_rd_a <= m2a[m2_raddr_a[7:0]];
    if (m2_we_a) begin
      m2a[m2_waddr_a[7:0]] <= m2_wval_a;
      wr_cnt_a <= wr_cnt_a + 1;
    end else if (tb_we_a) begin
      m2a[tb_waddr] <= tb_wval;
    end
    m1_rd_b <= m1b[m1_addr_b[0]];
    m2_rd_b <= m2b[m2_raddr_b[7:0]];
    if (m2_we_b)      m2b[m2_waddr_b[7:0]] <= m2_wval_b;
    else if (tb_we_b) m2b[tb_waddr] <= tb_wval;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [127:0] tw16(input int c);
    logic [127:0] v;
    v = '0;
    v[31:16] = 16'hAAAA;
    v[15:0]  = c[15:0];
    return v;
  endfunction

  function automatic logic [127:0] tw4(input int c);
    logic [127:0] v;
    v = '0;
    v[19:4] = 16'hAAAA;
    v[3:0]  = c[3:0];
    return v;
  endfunction

  function automatic logic [7:0] pat_pix(input int pat, input int j);
    case (pat)
      1:       return 8'h05;
      2:       return (j % 3 == 1) ? 8'h02 : 8'h01;
      3:       return (j % 4 == 0) ? 8'h07 : ((j % 4 == 1) ? 8'h09 : 8'h03);
      default: return (j < 20) ? 8'h00 : 8'h03;
    endcase
  endfunction

  function automatic logic s_busy(input int sel);
    return (sel != 0) ? busy_b : busy_a;
  endfunction

  function automatic logic s_done(input int sel);
    return (sel != 0) ? done_b : done_a;
  endfunction

  task automatic set_start(input int sel, input logic s, input logic cm);
    if (sel != 0) begin start_b = s; cm_b = cm; end
    else          begin start_a = s; cm_a = cm; end
  endtask

  task automatic set_image(input int sel, input int pat);
    for (int j = 0; j < NW * 16; j++) begin
      if (sel != 0) m1b[j / 16][(j % 16) * 8 +: 8] = pat_pix(pat, j);
      else          m1a[j / 16][(j % 16) * 8 +: 8] = pat_pix(pat, j);
    end
  endtask

  task automatic poke(input int sel, input int addr, input logic [127:0] val);
    @(negedge clk);
    tb_waddr = addr[7:0];
    tb_wval  = val;
    if (sel != 0) tb_we_b = 1'b1;
    else          tb_we_a = 1'b1;
    @(posedge clk);
    #1;
    tb_we_a = 1'b0;
    tb_we_b = 1'b0;
  endtask

  task automatic preload(input int sel, input logic [127:0] val);
    for (int b = 0; b < 256; b++) poke(sel, b, val);
  endtask

  task automatic clear_exp();
    for (int b = 0; b < 256; b++) exp_cnt[b] = 0;
  endtask

  task automatic check_bins(input int sel, input string pfx);
    for (int b = 0; b < 256; b++) begin
      if (sel != 0) chk($sformatf("%s_bin%0d", pfx, b), m2b[b], tw4(exp_cnt[b]));
      else          chk($sformatf("%s_bin%0d", pfx, b), m2a[b], tw16(exp_cnt[b]));
    end
  endtask

  // Starts a pass and follows it until a few cycles after done, bounded.
  task automatic run_pass(input int sel, input logic cm, input bit extra,
                          output int ndone, output logic busy0, output logic busy_end);
    int post;
    ndone = 0;
    post  = 0;
    busy0 = 1'b0;
    @(negedge clk);
    set_start(sel, 1'b1, cm);
    @(negedge clk);
    set_start(sel, 1'b0, 1'b0);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (i == 0) busy0 = s_busy(sel);
      if (s_done(sel)) ndone++;
      set_start(sel, 1'b0, 1'b0);
      if (extra && (i == 3 || i == 100 || i == 270)) set_start(sel, 1'b1, i[0]);
      if (ndone > 0) begin
        post++;
        if (post >= 5) break;
      end
    end
    busy_end = s_busy(sel);
  endtask

  int   nd;
  logic b0, be;
  int   wr_snap;

  initial begin
    rst_n    = 1'b0;
    start_a  = 1'b0; cm_a = 1'b0;
    start_b  = 1'b0; cm_b = 1'b0;
    tb_we_a  = 1'b0; tb_we_b = 1'b0;
    tb_waddr = '0;   tb_wval = '0;
    repeat (3) @(negedge clk);

    chk("rst_busy",   busy_a,     1'b0);
    chk("rst_done",   done_a,     1'b0);
    chk("rst_we",     m2_we_a,    1'b0);
    chk("rst_m1addr", m1_addr_a,  16'h0);
    chk("rst_m2raddr",m2_raddr_a, 16'h0);
    chk("rst_m2waddr",m2_waddr_a, 16'h0);
    chk("rst_busy_b", busy_b,     1'b0);
    rst_n = 1'b1;

    // Clear pass over stale tagged data; every pixel is 5.
    preload(0, tw16(99));
    set_image(0, 1);
    run_pass(0, 1'b1, 1'b0, nd, b0, be);
    chk("t1_busy_start", b0, 1'b1);
    chk("t1_busy_end",   be, 1'b0);
    chk("t1_done_count", nd, 1);
    clear_exp();
    exp_cnt[5] = 32;
    check_bins(0, "t1");

    // Alternating 1,2,1 pattern: 21 ones and 11 twos.
    set_image(0, 2);
    run_pass(0, 1'b1, 1'b0, nd, b0, be);
    chk("t2_done_count", nd, 1);
    clear_exp();
    exp_cnt[1] = 21;
    exp_cnt[2] = 11;
    check_bins(0, "t2");

    // No clear: untagged bin 7 starts from zero, tagged bin 9 from 5.
    preload(0, tw16(0));
    poke(0, 7, 128'h1234);
    poke(0, 9, tw16(5));
    set_image(0, 3);
    run_pass(0, 1'b0, 1'b0, nd, b0, be);
    chk("t3_done_count", nd, 1);
    clear_exp();
    exp_cnt[7] = 8;
    exp_cnt[9] = 13;
    exp_cnt[3] = 16;
    check_bins(0, "t3");

    // Reset in the middle of COUNT, then a fresh pass.
    set_image(0, 1);
    @(negedge clk);
    set_start(0, 1'b1, 1'b1);
    @(negedge clk);
    set_start(0, 1'b0, 1'b0);
    repeat (265) @(negedge clk);
    chk("t4_busy_before", busy_a,  1'b1);
    chk("t4_we_before",   m2_we_a, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t4_we_reset",   m2_we_a,   1'b0);
    chk("t4_busy_reset", busy_a,    1'b0);
    chk("t4_done_reset", done_a,    1'b0);
    chk("t4_m1_reset",   m1_addr_a, 16'h0);
    wr_snap = wr_cnt_a;
    repeat (3) @(negedge clk);
    chk("t4_no_writes", wr_cnt_a, wr_snap);
    rst_n = 1'b1;
    set_image(0, 2);
    run_pass(0, 1'b1, 1'b0, nd, b0, be);
    chk("t4_done_count", nd, 1);
    clear_exp();
    exp_cnt[1] = 21;
    exp_cnt[2] = 11;
    check_bins(0, "t4");

    // Start pulses while busy must be ignored.
    set_image(0, 1);
    run_pass(0, 1'b1, 1'b1, nd, b0, be);
    chk("t5_done_count", nd, 1);
    chk("t5_busy_end",   be, 1'b0);
    chk("t5_bin5",       m2a[5], tw16(32));
    chk("t5_bin4",       m2a[4], tw16(0));

    // Four-bit counters: twenty zeros saturate at 15.
    set_image(1, 4);
    run_pass(1, 1'b1, 1'b0, nd, b0, be);
    chk("t6_done_count", nd, 1);
    clear_exp();
    exp_cnt[0] = 15;
    exp_cnt[3] = 12;
    check_bins(1, "t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
